// File: rtl/score_keeper.sv
// score_keeper: BCD game score, session high score and play/game-over control
// for the 2-digit 7-segment display. In OVER the display blinks with a
// half-period of BLINK_DIV clock cycles.
module score_keeper #(
  parameter int unsigned BLINK_DIV = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       food_eaten,
  input  logic       game_over,
  input  logic       new_game,
  input  logic       show_high,
  output logic [7:0] num,
  output logic       enable,
  output logic [7:0] high_score,
  output logic [1:0] state
);

  localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_PLAY = 2'b01,
    S_OVER = 2'b10,
    S_ILL  = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       score_q, score_d;
  logic [7:0]       high_q, high_d;
  logic [7:0]       num_q, num_d;
  logic             enable_q, enable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Packed-BCD increment that sticks at 99.
  function automatic logic [7:0] bcd_inc_sat(input logic [7:0] v);
    logic [3:0] tens;
    logic [3:0] units;
    tens  = v[7:4];
    units = v[3:0];
    if (v == 8'h99) begin
      bcd_inc_sat = v;
    end else if (units >= 4'd9) begin
      bcd_inc_sat = {tens + 4'd1, 4'd0};
    end else begin
      bcd_inc_sat = {tens, units + 4'd1};
    end
  endfunction

  // Next-state, score/high-score update, blink timing and display selection.
  always_comb begin
    state_d  = state_q;
    score_d  = score_q;
    high_d   = high_q;
    enable_d = enable_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        enable_d = 1'b1;
        if (new_game) begin
          state_d = S_PLAY;
          score_d = 8'h00;
        end
      end
      S_PLAY: begin
        enable_d = 1'b1;
        // game_over takes priority over both restart and food.
        if (game_over) begin
          state_d  = S_OVER;
          enable_d = 1'b0;
          cnt_d    = '0;
          if (score_q > high_q) high_d = score_q;
        end else if (new_game) begin
          score_d = 8'h00;
        end else if (food_eaten) begin
          score_d = bcd_inc_sat(score_q);
        end
      end
      S_OVER: begin
        if (new_game) begin
          state_d  = S_PLAY;
          score_d  = 8'h00;
          enable_d = 1'b1;
          cnt_d    = '0;
        end else if (cnt_q == CNT_MAX) begin
          cnt_d    = '0;
          enable_d = ~enable_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        // Unreachable encoding: recover to IDLE, keep the high score.
        state_d  = S_IDLE;
        score_d  = 8'h00;
        enable_d = 1'b1;
        cnt_d    = '0;
      end
    endcase
    // Select from next-state values so num tracks the registered outputs.
    if (state_d != S_PLAY && show_high) begin
      num_d = high_d;
    end else begin
      num_d = score_d;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      score_q  <= 8'h00;
      high_q   <= 8'h00;
      num_q    <= 8'h00;
      enable_q <= 1'b1;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      score_q  <= score_d;
      high_q   <= high_d;
      num_q    <= num_d;
      enable_q <= enable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign num        = num_q;
  assign enable     = enable_q;
  assign high_score = high_q;
  assign state      = state_q;

endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper: directed stimulus for score_keeper with a cycle-level
// behavioural model (integer score, cycles-since-game-over blink) compared
// on every falling edge, plus literal expectations at key points.
module tb_score_keeper;

  localparam int BD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       food_eaten = 1'b0;
  logic       game_over = 1'b0;
  logic       new_game = 1'b0;
  logic       show_high = 1'b0;
  logic [7:0] num;
  logic       enable;
  logic [7:0] high_score;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  score_keeper #(.BLINK_DIV(BD)) dut (
    .clk        (clk),
    .rst        (rst),
    .food_eaten (food_eaten),
    .game_over  (game_over),
    .new_game   (new_game),
    .show_high  (show_high),
    .num        (num),
    .enable     (enable),
    .high_score (high_score),
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  // Behavioural model: integer score 0..99, state 0 idle / 1 play / 2 over,
  // blink derived from the number of cycles spent in OVER.
  int         m_state = 0;
  int         m_score = 0;
  int         m_high = 0;
  int         m_ov = 0;
  bit         m_en = 1'b1;
  logic [7:0] m_num = 8'h00;
  bit         m_valid = 1'b0;

  always @(posedge clk) begin : model
    int s, sc, hi, ov;
    bit en;
    logic [7:0] nm;
    s = m_state; sc = m_score; hi = m_high; ov = m_ov;
    if (rst) begin
      s = 0; sc = 0; hi = 0; ov = 0;
    end else begin
      case (s)
        0: if (new_game) begin s = 1; sc = 0; end
        1: begin
          if (game_over) begin
            s = 2; ov = 0;
            if (sc > hi) hi = sc;
          end else if (new_game) sc = 0;
          else if (food_eaten && sc < 99) sc = sc + 1;
        end
        default: begin
          if (new_game) begin s = 1; sc = 0; end
          else ov = ov + 1;
        end
      endcase
    end
    en = (s != 2) || (((ov / BD) % 2) == 1);
    if (rst) nm = 8'h00;
    else nm = (s != 1 && show_high) ? to_bcd(hi) : to_bcd(sc);
    m_state <= s; m_score <= sc; m_high <= hi; m_ov <= ov;
    m_en <= en; m_num <= nm; m_valid <= 1'b1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_state", 32'(state), 32'(m_state));
      chk("model_num", 32'(num), 32'(m_num));
      chk("model_enable", 32'(enable), 32'(m_en));
      chk("model_high", 32'(high_score), 32'(to_bcd(m_high)));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input bit fe, input bit go, input bit ng);
    food_eaten = fe; game_over = go; new_game = ng;
    tick();
    food_eaten = 1'b0; game_over = 1'b0; new_game = 1'b0;
  endtask

  task automatic feed(input int n);
    for (int i = 0; i < n; i++) apply(1'b1, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    tick(); tick();
    rst = 1'b0;
    chk("rst_state", 32'(state), 32'h0);
    chk("rst_num", 32'(num), 32'h00);
    chk("rst_high", 32'(high_score), 32'h00);
    chk("rst_enable", 32'(enable), 32'h1);

    // IDLE ignores food and game_over.
    apply(1'b1, 1'b0, 1'b0);
    apply(1'b0, 1'b1, 1'b0);
    chk("idle_ignore_state", 32'(state), 32'h0);
    chk("idle_ignore_num", 32'(num), 32'h00);

    // 1: twelve increments.
    apply(1'b0, 1'b0, 1'b1);
    chk("start_state", 32'(state), 32'h1);
    feed(12);
    chk("count12_num", 32'(num), 32'h12);
    chk("count12_en", 32'(enable), 32'h1);

    // 2: decade carry and saturation.
    apply(1'b0, 1'b0, 1'b1);
    chk("restart_num", 32'(num), 32'h00);
    feed(9);
    chk("num09", 32'(num), 32'h09);
    feed(1);
    chk("carry_10", 32'(num), 32'h10);
    feed(89);
    chk("num99", 32'(num), 32'h99);
    feed(3);
    chk("sat99", 32'(num), 32'h99);

    // 3: game over updates high score, then blink at BD=4.
    apply(1'b0, 1'b0, 1'b1);
    feed(37);
    apply(1'b0, 1'b1, 1'b0);
    chk("over_state", 32'(state), 32'h2);
    chk("over_high", 32'(high_score), 32'h37);
    for (int k = 0; k < 24; k++) begin
      chk("blink", 32'(enable), 32'((k / 4) % 2));
      tick();
    end

    // 4: simultaneous game_over and food; high score retention.
    do_reset();
    apply(1'b0, 1'b0, 1'b1);
    feed(5);
    apply(1'b1, 1'b1, 1'b0);
    chk("go_wins_state", 32'(state), 32'h2);
    chk("go_wins_num", 32'(num), 32'h05);
    chk("go_wins_high", 32'(high_score), 32'h05);
    apply(1'b0, 1'b0, 1'b1);
    feed(3);
    apply(1'b0, 1'b1, 1'b0);
    chk("high_kept", 32'(high_score), 32'h05);
    show_high = 1'b1;
    tick();
    chk("show_high_num", 32'(num), 32'h05);
    show_high = 1'b0;
    tick();
    chk("show_score_num", 32'(num), 32'h03);
    chk("dark_before_ng", 32'(enable), 32'h0);

    // 5: restart from OVER mid-blink; show_high ignored in PLAY.
    apply(1'b0, 1'b0, 1'b1);
    chk("ng_over_state", 32'(state), 32'h1);
    chk("ng_over_num", 32'(num), 32'h00);
    chk("ng_over_en", 32'(enable), 32'h1);
    show_high = 1'b1;
    feed(1);
    chk("play_show_high", 32'(num), 32'h01);
    tick();
    chk("play_show_high2", 32'(num), 32'h01);
    show_high = 1'b0;

    // new_game with game_over in PLAY: game_over wins.
    apply(1'b0, 1'b1, 1'b1);
    chk("go_over_ng", 32'(state), 32'h2);

    // 6: reset mid-play.
    do_reset();
    apply(1'b0, 1'b0, 1'b1);
    feed(20);
    apply(1'b0, 1'b1, 1'b0);
    chk("high20", 32'(high_score), 32'h20);
    apply(1'b0, 1'b0, 1'b1);
    feed(42);
    chk("num42", 32'(num), 32'h42);
    rst = 1'b1;
    tick();
    chk("rst_play_state", 32'(state), 32'h0);
    chk("rst_play_num", 32'(num), 32'h00);
    chk("rst_play_high", 32'(high_score), 32'h00);
    chk("rst_play_en", 32'(enable), 32'h1);
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    chk("rst_vs_ng", 32'(state), 32'h0);
    rst = 1'b0;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
